// File: rtl/video_source_switch.sv
// ---------------------------------------------------------------------------
// video_source_switch
// Selects between an HDMI input stream and a colour-bar pattern stream, both
// synchronous to clk. The input is used only once it has held lock for
// LOCK_FRAMES frames. Requested switches are aligned to the vsync rise of the
// new source. Lock loss or a vsync watchdog timeout forces an immediate
// return to the pattern.
//
// Parameters
//   LOCK_FRAMES : consecutive locked input frames before the input qualifies
//   VS_TIMEOUT  : max clk cycles between input vsync rises before input is lost
//
// Ports
//   clk, rst                 : pixel clock, async active-low reset
//   sel_req                  : 1 = request HDMI input, 0 = request pattern
//   in_locked                : HDMI receiver lock
//   in_* (hsync/vsync/de/rgb): HDMI input stream
//   pg_* (hsync/vsync/de/rgb): colour-bar generator stream
//   hsync/vsync/de/red/green/blue : selected stream, 1 clk latency
//   active_src               : 1 = input currently driving the outputs
//   in_ok                    : input qualified
//
// Optional feature: define SOURCE_SWITCH_MUTE_EN to blank de/rgb for one
// output frame after every switch (hsync/vsync keep passing through).
// ---------------------------------------------------------------------------
module video_source_switch #(
  parameter int unsigned LOCK_FRAMES = 4,
  parameter int unsigned VS_TIMEOUT  = 2000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sel_req,
  input  logic       in_locked,
  input  logic       in_hsync,
  input  logic       in_vsync,
  input  logic       in_de,
  input  logic [7:0] in_red,
  input  logic [7:0] in_green,
  input  logic [7:0] in_blue,
  input  logic       pg_hsync,
  input  logic       pg_vsync,
  input  logic       pg_de,
  input  logic [7:0] pg_red,
  input  logic [7:0] pg_green,
  input  logic [7:0] pg_blue,
  output logic       hsync,
  output logic       vsync,
  output logic       de,
  output logic [7:0] red,
  output logic [7:0] green,
  output logic [7:0] blue,
  output logic       active_src,
  output logic       in_ok
);

  localparam int unsigned LW = $clog2(LOCK_FRAMES + 1);
  localparam int unsigned WW = $clog2(VS_TIMEOUT + 1);
  localparam int unsigned SW = 27;

  localparam logic [1:0] ST_PATTERN = 2'd0;
  localparam logic [1:0] ST_ARM_IN  = 2'd1;
  localparam logic [1:0] ST_INPUT   = 2'd2;
  localparam logic [1:0] ST_ARM_PAT = 2'd3;

  logic [1:0]    state;
  logic [1:0]    state_next;
  logic          in_vs_q;
  logic          pg_vs_q;
  logic [LW-1:0] lock_cnt;
  logic [LW-1:0] lock_next;
  logic [WW-1:0] wd_cnt;
  logic [WW-1:0] wd_next;
  logic          in_rise_c;
  logic          pg_rise_c;
  logic          wd_expire_c;
  logic          lock_ok_c;
  logic          force_c;
  logic          route_c;
  logic [SW-1:0] stream_c;
  logic [SW-1:0] out_c;

  // Vsync rise detection against the previous sample
  assign in_rise_c = in_vsync & ~in_vs_q;
  assign pg_rise_c = pg_vsync & ~pg_vs_q;

  // A vsync rise in the same cycle rescues the input from a pending expiry
  assign wd_expire_c = (wd_cnt == WW'(VS_TIMEOUT)) & ~in_rise_c;
  assign lock_ok_c   = (lock_cnt == LW'(LOCK_FRAMES));
  assign force_c     = ~in_locked | wd_expire_c;

  // Lock qualifier and watchdog next values
  always_comb begin
    lock_next = lock_cnt;
    if (!in_locked) begin
      lock_next = '0;
    end else if (in_rise_c) begin
      if (!lock_ok_c) lock_next = lock_cnt + LW'(1);
    end else if (wd_expire_c) begin
      lock_next = '0;
    end
    wd_next = wd_cnt;
    if (in_rise_c) begin
      wd_next = '0;
    end else if (wd_cnt != WW'(VS_TIMEOUT)) begin
      wd_next = wd_cnt + WW'(1);
    end
  end

  // Next-state logic; forced fallback outranks every other transition
  always_comb begin
    state_next = state;
    case (state)
      ST_PATTERN: begin
        if (sel_req && lock_ok_c) state_next = ST_ARM_IN;
      end
      ST_ARM_IN: begin
        if (!sel_req || !lock_ok_c) state_next = ST_PATTERN;
        else if (in_rise_c)         state_next = ST_INPUT;
      end
      ST_INPUT: begin
        if (force_c)       state_next = ST_PATTERN;
        else if (!sel_req) state_next = ST_ARM_PAT;
      end
      ST_ARM_PAT: begin
        if (force_c)        state_next = ST_PATTERN;
        else if (sel_req)   state_next = ST_INPUT;
        else if (pg_rise_c) state_next = ST_PATTERN;
      end
      default: state_next = ST_PATTERN;
    endcase
  end

  // Route from the next state so the triggering vsync rise comes from the new source
  assign route_c  = (state_next == ST_INPUT) || (state_next == ST_ARM_PAT);
  assign stream_c = route_c ?
                    {in_hsync, in_vsync, in_de, in_red, in_green, in_blue} :
                    {pg_hsync, pg_vsync, pg_de, pg_red, pg_green, pg_blue};

`ifdef SOURCE_SWITCH_MUTE_EN
  logic mute_q;
  logic mute_next_c;

  // Mute starts on a source change and ends at the following output vsync rise
  always_comb begin
    mute_next_c = mute_q;
    if (route_c != active_src) begin
      mute_next_c = 1'b1;
    end else if (stream_c[25] && !vsync) begin
      mute_next_c = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) mute_q <= 1'b0;
    else      mute_q <= mute_next_c;
  end

  assign out_c = mute_next_c ? {stream_c[26:25], 25'd0} : stream_c;
`else
  assign out_c = stream_c;
`endif

  // State, qualifier and watchdog registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_PATTERN;
      in_vs_q  <= 1'b0;
      pg_vs_q  <= 1'b0;
      lock_cnt <= '0;
      wd_cnt   <= '0;
    end else begin
      state    <= state_next;
      in_vs_q  <= in_vsync;
      pg_vs_q  <= pg_vsync;
      lock_cnt <= lock_next;
      wd_cnt   <= wd_next;
    end
  end

  // Registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hsync      <= 1'b0;
      vsync      <= 1'b0;
      de         <= 1'b0;
      red        <= 8'd0;
      green      <= 8'd0;
      blue       <= 8'd0;
      active_src <= 1'b0;
      in_ok      <= 1'b0;
    end else begin
      {hsync, vsync, de, red, green, blue} <= out_c;
      active_src <= route_c;
      in_ok      <= (lock_next == LW'(LOCK_FRAMES));
    end
  end

endmodule

// File: tb/tb_video_source_switch.sv
// ---------------------------------------------------------------------------
// tb_video_source_switch
// Drives two free-running video streams with random pixel data and checks
// video_source_switch every cycle against a behavioural reference model,
// plus scenario checks for qualification, return, lock loss, watchdog,
// abort and reset behaviour.
// ---------------------------------------------------------------------------
module tb_video_source_switch;

  localparam int unsigned LF  = 2;
  localparam int unsigned VT  = 1000;
  localparam int unsigned PER = 500;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic sel_req = 1'b0;
  logic in_locked = 1'b0;
  logic in_hsync = 1'b0, in_vsync = 1'b0, in_de = 1'b0;
  logic [7:0] in_red = 8'd0, in_green = 8'd0, in_blue = 8'd0;
  logic pg_hsync = 1'b0, pg_vsync = 1'b0, pg_de = 1'b0;
  logic [7:0] pg_red = 8'd0, pg_green = 8'd0, pg_blue = 8'd0;
  logic hsync, vsync, de, active_src, in_ok;
  logic [7:0] red, green, blue;

  int n_checks = 0;
  int n_fail   = 0;

  bit in_vs_en = 1'b1;
  int unsigned pg_ph = 0;
  int unsigned in_ph = 200;

  video_source_switch #(.LOCK_FRAMES(LF), .VS_TIMEOUT(VT)) dut (
    .clk(clk), .rst(rst), .sel_req(sel_req), .in_locked(in_locked),
    .in_hsync(in_hsync), .in_vsync(in_vsync), .in_de(in_de),
    .in_red(in_red), .in_green(in_green), .in_blue(in_blue),
    .pg_hsync(pg_hsync), .pg_vsync(pg_vsync), .pg_de(pg_de),
    .pg_red(pg_red), .pg_green(pg_green), .pg_blue(pg_blue),
    .hsync(hsync), .vsync(vsync), .de(de),
    .red(red), .green(green), .blue(blue),
    .active_src(active_src), .in_ok(in_ok)
  );

  always #5 clk = ~clk;

  // Two streams with 500-cycle frames, offset phases and random pixels
  always @(posedge clk) begin
    #1;
    pg_ph    = (pg_ph + 1) % PER;
    in_ph    = (in_ph + 1) % PER;
    pg_vsync = (pg_ph < 3);
    pg_hsync = ((pg_ph % 50) < 4);
    pg_de    = ((pg_ph % 50) >= 8);
    pg_red   = 8'($urandom);
    pg_green = 8'($urandom);
    pg_blue  = 8'($urandom);
    in_vsync = in_vs_en && (in_ph < 3);
    in_hsync = ((in_ph % 50) < 4);
    in_de    = ((in_ph % 50) >= 8);
    in_red   = 8'($urandom);
    in_green = 8'($urandom);
    in_blue  = 8'($urandom);
  end

  // Reference model: which source is live, whether a switch is pending,
  // how many locked frames were seen and how long since the last input frame.
  bit          m_use, m_arm, m_in_prev, m_pg_prev, m_out_vs, m_mute, m_last_pg_rise;
  int unsigned m_lock, m_wd, m_since_rise, m_in_rises;
  logic [28:0] e_vec;
  logic [26:0] d_pg, d_in;
  wire  [28:0] out_vec = {active_src, in_ok, hsync, vsync, de, red, green, blue};

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_use = 0; m_arm = 0; m_in_prev = 0; m_pg_prev = 0; m_out_vs = 0;
      m_mute = 0; m_last_pg_rise = 0; m_lock = 0; m_wd = 0; m_since_rise = 0;
      e_vec = '0;
    end else begin
      bit ir, pr, expired, old_use;
      logic [26:0] s;
      ir      = in_vsync && !m_in_prev;
      pr      = pg_vsync && !m_pg_prev;
      expired = (m_wd >= VT) && !ir;
      old_use = m_use;
      if (!m_use) begin
        if (!m_arm) m_arm = sel_req && (m_lock == LF);
        else if (!sel_req || m_lock != LF) m_arm = 0;
        else if (ir) begin m_use = 1; m_arm = 0; end
      end else begin
        if (!in_locked || expired) begin m_use = 0; m_arm = 0; end
        else if (!m_arm) m_arm = !sel_req;
        else if (sel_req) m_arm = 0;
        else if (pr) begin m_use = 0; m_arm = 0; end
      end
      if (!in_locked) m_lock = 0;
      else if (ir) m_lock = (m_lock < LF) ? m_lock + 1 : LF;
      else if (expired) m_lock = 0;
      m_wd = ir ? 0 : ((m_wd < VT) ? m_wd + 1 : VT);
      m_since_rise = ir ? 0 : m_since_rise + 1;
      if (ir) m_in_rises = m_in_rises + 1;
      m_last_pg_rise = pr;
      d_pg = {pg_hsync, pg_vsync, pg_de, pg_red, pg_green, pg_blue};
      d_in = {in_hsync, in_vsync, in_de, in_red, in_green, in_blue};
      s = m_use ? d_in : d_pg;
`ifdef SOURCE_SWITCH_MUTE_EN
      if (m_use != old_use) m_mute = 1;
      else if (s[25] && !m_out_vs) m_mute = 0;
      if (m_mute) s[24:0] = '0;
`else
      m_mute = old_use && 1'b0;
`endif
      m_out_vs = s[25];
      e_vec = {m_use, (m_lock == LF), s};
      m_in_prev = in_vsync;
      m_pg_prev = pg_vsync;
    end
  end

  function automatic logic [26:0] switched(input logic [26:0] v);
    logic [26:0] r;
    r = v;
`ifdef SOURCE_SWITCH_MUTE_EN
    r[24:0] = '0;
`endif
    return r;
  endfunction

  task automatic test_reset();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_checks++;
      if (out_vec !== 29'd0) begin
        n_fail++; $display("FAIL reset_zero got=%h exp=0", out_vec);
      end
    end
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if (out_vec !== {2'b00, d_pg}) begin
      n_fail++; $display("FAIL reset_first_pg got=%h exp=%h", out_vec, {2'b00, d_pg});
    end
  endtask

  task automatic test_qualified();
    int unsigned base;
    bit seen_ok, done;
    @(posedge clk); #1;
    base = m_in_rises; in_locked = 1'b1; sel_req = 1'b1;
    seen_ok = 0; done = 0;
    for (int i = 0; i < 3000 && !done; i++) begin
      @(negedge clk);
      n_checks++;
      if (out_vec !== e_vec) begin
        n_fail++; $display("FAIL qual_model got=%h exp=%h", out_vec, e_vec);
      end
      if (in_ok && !seen_ok) begin
        seen_ok = 1; n_checks++;
        if (m_in_rises - base != 2) begin
          n_fail++; $display("FAIL qual_in_ok_rises got=%0d exp=2", m_in_rises - base);
        end
      end
      if (active_src) begin
        done = 1; n_checks += 2;
        if (m_in_rises - base != 3) begin
          n_fail++; $display("FAIL qual_active_rises got=%0d exp=3", m_in_rises - base);
        end
        if (out_vec[26:0] !== switched(d_in)) begin
          n_fail++; $display("FAIL qual_in_data got=%h exp=%h", out_vec[26:0], switched(d_in));
        end
      end
    end
    if (!done) begin n_fail++; $display("FAIL qual_timeout got=0 exp=1"); end
  endtask

  task automatic test_return();
    bit done;
    @(posedge clk); #1; sel_req = 1'b0;
    done = 0;
    for (int i = 0; i < 1200 && !done; i++) begin
      @(negedge clk);
      n_checks++;
      if (out_vec !== e_vec) begin
        n_fail++; $display("FAIL ret_model got=%h exp=%h", out_vec, e_vec);
      end
      if (!active_src) begin
        done = 1; n_checks++;
        if (!m_last_pg_rise || vsync !== 1'b1 || out_vec[26:0] !== switched(d_pg)) begin
          n_fail++; $display("FAIL ret_at_pg_vsync got=%h exp=%h", out_vec[26:0], switched(d_pg));
        end
      end
    end
    if (!done) begin n_fail++; $display("FAIL ret_timeout got=1 exp=0"); end
  endtask

  task automatic test_lock_loss();
    bit done;
    @(posedge clk); #1; sel_req = 1'b1;
    done = 0;
    for (int i = 0; i < 1500 && !done; i++) begin
      @(negedge clk);
      n_checks++;
      if (out_vec !== e_vec) begin
        n_fail++; $display("FAIL ll_model got=%h exp=%h", out_vec, e_vec);
      end
      if (active_src && (in_ph % 50) == 25) done = 1;
    end
    if (!done) begin n_fail++; $display("FAIL ll_arm_timeout got=0 exp=1"); end
    @(posedge clk); #1; in_locked = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_checks++;
      if (out_vec !== e_vec) begin
        n_fail++; $display("FAIL ll_model_drop got=%h exp=%h", out_vec, e_vec);
      end
    end
    n_checks++;
    if (active_src !== 1'b0 || in_ok !== 1'b0 || out_vec[26:0] !== switched(d_pg)) begin
      n_fail++; $display("FAIL ll_fallback got=%h exp=%h", out_vec, {2'b00, switched(d_pg)});
    end
    in_locked = 1'b1;
  endtask

  task automatic test_watchdog();
    int unsigned base;
    bit done;
    sel_req = 1'b1;
    done = 0;
    for (int i = 0; i < 3000 && !done; i++) begin
      @(negedge clk);
      n_checks++;
      if (out_vec !== e_vec) begin
        n_fail++; $display("FAIL wd_model_arm got=%h exp=%h", out_vec, e_vec);
      end
      if (active_src) done = 1;
    end
    if (!done) begin n_fail++; $display("FAIL wd_arm_timeout got=0 exp=1"); end
    in_vs_en = 1'b0;
    done = 0;
    for (int i = 0; i < 1500 && !done; i++) begin
      @(negedge clk);
      n_checks++;
      if (out_vec !== e_vec) begin
        n_fail++; $display("FAIL wd_model got=%h exp=%h", out_vec, e_vec);
      end
      if (!active_src) begin
        done = 1; n_checks++;
        if (m_since_rise != VT + 1 || in_ok !== 1'b0) begin
          n_fail++; $display("FAIL wd_expiry got=%0d/%b exp=%0d/0", m_since_rise, in_ok, VT + 1);
        end
      end
    end
    if (!done) begin n_fail++; $display("FAIL wd_timeout got=1 exp=0"); end
    base = m_in_rises; in_vs_en = 1'b1;
    done = 0;
    for (int i = 0; i < 2000 && !done; i++) begin
      @(negedge clk);
      n_checks++;
      if (out_vec !== e_vec) begin
        n_fail++; $display("FAIL wd_model_rearm got=%h exp=%h", out_vec, e_vec);
      end
      if (in_ok) begin
        done = 1; n_checks++;
        if (m_in_rises - base != 2) begin
          n_fail++; $display("FAIL wd_rearm_rises got=%0d exp=2", m_in_rises - base);
        end
      end
    end
    if (!done) begin n_fail++; $display("FAIL wd_rearm_timeout got=0 exp=1"); end
  endtask

  task automatic test_abort();
    bit done;
    sel_req = 1'b0;
    done = 0;
    for (int i = 0; i < 3000 && !done; i++) begin
      @(negedge clk);
      if (!active_src && in_ph == 300) done = 1;
    end
    if (!done) begin n_fail++; $display("FAIL abort_setup_timeout got=1 exp=0"); end
    // Drop the request well before the arming vsync
    sel_req = 1'b1;
    repeat (20) @(negedge clk);
    sel_req = 1'b0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      n_checks++;
      if (active_src !== 1'b0 || out_vec !== e_vec) begin
        n_fail++; $display("FAIL abort_early got=%h exp=%h", out_vec, e_vec);
      end
    end
    // Drop the request in the same cycle as the arming vsync rise
    sel_req = 1'b1;
    done = 0;
    for (int i = 0; i < 600 && !done; i++) begin
      @(posedge clk); #2;
      if (in_ph == 0) done = 1;
    end
    sel_req = 1'b0;
    if (!done) begin n_fail++; $display("FAIL abort_sync_timeout got=0 exp=1"); end
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      n_checks++;
      if (active_src !== 1'b0 || out_vec !== e_vec) begin
        n_fail++; $display("FAIL abort_same_cycle got=%h exp=%h", out_vec, e_vec);
      end
    end
  endtask

  task automatic test_reset_mid_switch();
    bit done;
    done = 0;
    sel_req = 1'b1;
    for (int i = 0; i < 600 && !done; i++) begin
      @(negedge clk);
      if (in_ph == 300) done = 1;
    end
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (out_vec !== 29'd0) begin
      n_fail++; $display("FAIL rst_mid_zero got=%h exp=0", out_vec);
    end
    rst = 1'b1;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      n_checks++;
      if (active_src !== 1'b0 || out_vec !== e_vec) begin
        n_fail++; $display("FAIL rst_mid_hold got=%h exp=%h", out_vec, e_vec);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 9000; i++) begin
      @(negedge clk);
      n_checks++;
      if (out_vec !== e_vec) begin
        n_fail++; $display("FAIL rand_model cyc=%0d got=%h exp=%h", i, out_vec, e_vec);
      end
      if ($urandom_range(0, 599) == 0) sel_req = ~sel_req;
      if (in_locked && $urandom_range(0, 2999) == 0) in_locked = 1'b0;
      else if (!in_locked && $urandom_range(0, 199) == 0) in_locked = 1'b1;
      if (in_vs_en && $urandom_range(0, 3999) == 0) in_vs_en = 1'b0;
      else if (!in_vs_en && $urandom_range(0, 1499) == 0) in_vs_en = 1'b1;
    end
  endtask

  initial begin
    test_reset();
    test_qualified();
    test_return();
    test_lock_loss();
    test_watchdog();
    test_abort();
    test_reset_mid_switch();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/video_source_switch.md
VIDEO_SOURCE_SWITCH -- requirements
Module: video_source_switch

Interface
REQ-001 The block SHALL have parameter LOCK_FRAMES, default 4, meaning the number of consecutive input frames with lock required before the input is eligible.
REQ-002 The block SHALL have parameter VS_TIMEOUT, default 2000000, meaning the maximum number of clk cycles between input vsync rising edges before the input is declared lost.
REQ-003 The block SHALL have port clk, input, 1 bit: the single pixel clock; both sources are synchronous to it.
REQ-004 The block SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port sel_req, input, 1 bit: 1 = request HDMI input, 0 = request colour-bar pattern.
REQ-006 The block SHALL have port in_locked, input, 1 bit: HDMI receiver lock.
REQ-007 The block SHALL have ports in_hsync, in_vsync and in_de, input, 1 bit each, plus in_red, in_green and in_blue, input, 8 bits each: the HDMI input stream.
REQ-008 The block SHALL have ports pg_hsync, pg_vsync and pg_de, input, 1 bit each, plus pg_red, pg_green and pg_blue, input, 8 bits each: the colorbar_generator stream.
REQ-009 The block SHALL have ports hsync, vsync and de, output, 1 bit each, plus red, green and blue, output, 8 bits each: the selected stream.
REQ-010 The block SHALL have port active_src, output, 1 bit: 1 = input currently driving outputs.
REQ-011 The block SHALL have port in_ok, output, 1 bit: input qualified (REQ-015).

Function
REQ-012 All outputs SHALL be registered, and the selected stream SHALL appear at the outputs with exactly 1 clk of latency.
REQ-013 The FSM SHALL have states PATTERN, ARM_IN, INPUT and ARM_PAT; active_src SHALL be 1 only in INPUT and ARM_PAT.
REQ-014 Vsync edge detection SHALL register in_vsync and pg_vsync; a rise is the current sample equal to 1 with the previous sample equal to 0.
REQ-015 Lock qualifier: lock_cnt SHALL increment on each in_vsync rise while in_locked=1, saturate at LOCK_FRAMES, and clear to 0 when in_locked=0 or on watchdog expiry; in_ok SHALL equal (lock_cnt == LOCK_FRAMES).
REQ-016 Watchdog: a cycle counter SHALL clear on each in_vsync rise and saturate; expiry SHALL be the counter reaching VS_TIMEOUT.
REQ-017 Transition PATTERN->ARM_IN SHALL occur when sel_req=1 and in_ok=1.
REQ-018 In ARM_IN, the FSM SHALL move to INPUT on the next in_vsync rise, and SHALL return to PATTERN if sel_req=0 or in_ok=0 first.
REQ-019 Transition INPUT->ARM_PAT SHALL occur when sel_req=0.
REQ-020 In ARM_PAT, the FSM SHALL move to PATTERN on the next pg_vsync rise, and SHALL return to INPUT if sel_req=1 first.
REQ-021 Forced fallback: in INPUT or ARM_PAT, in_locked=0 or watchdog expiry SHALL move the FSM to PATTERN on the next edge, with no frame alignment; this SHALL take priority over every other transition.
REQ-022 The vsync rise that triggers a switch SHALL already be routed from the new source, so that the output frame starts cleanly.
REQ-023 When sel_req toggles in the same cycle as the arming vsync rise, the FSM SHALL take the ARM abort path; the switch SHALL NOT be taken.

Reset
REQ-024 While rst=0, the FSM SHALL be in PATTERN, lock_cnt and the watchdog SHALL be 0, and hsync, vsync, de, red, green, blue, active_src and in_ok SHALL all be 0.
REQ-025 After rst rises, the first output cycle SHALL carry pattern data.
REQ-026 Reset asserted mid-switch SHALL abandon any pending ARM state.

Configuration
REQ-027 Macro SOURCE_SWITCH_MUTE_EN: when it is defined, for one full output frame after any switch (aligned or forced), de, red, green and blue SHALL be forced to 0 while hsync and vsync pass through; the mute SHALL end at the next output vsync rise.
REQ-028 When SOURCE_SWITCH_MUTE_EN is undefined, no mute logic SHALL be present and data SHALL pass through immediately.

Verification (bench: LOCK_FRAMES=2, VS_TIMEOUT=1000, vsync period 500 cycles)
REQ-029 Reset: rst=0 for 10 cycles with both streams active -> all outputs are 0; 1 cycle after rst=1, outputs equal the pg_* inputs delayed by 1.
REQ-030 Qualified switch: in_locked=1, sel_req=1 -> in_ok rises after the 2nd in_vsync rise; active_src rises at the 3rd in_vsync rise; outputs equal in_* delayed by 1 from then on.
REQ-031 Return to pattern: in INPUT, sel_req=0 -> active_src stays 1 until the next pg_vsync rise, then falls; outputs equal pg_* from that vsync onward.
REQ-032 Lock loss: in INPUT, in_locked=0 mid-line -> active_src=0 and outputs equal pg_* 2 cycles later; in_ok=0.
REQ-033 Watchdog: in INPUT, in_vsync held low for 1000 cycles -> forced fallback to PATTERN; in_ok=0; re-arming requires 2 fresh in_vsync rises.
REQ-034 Abort: in ARM_IN, sel_req drops before the in_vsync rise -> state returns to PATTERN and active_src never rises; with SOURCE_SWITCH_MUTE_EN, a REQ-030 switch shows de=0 for exactly one frame.
